hvtx_sched: RTL and testbench

HVTX_SCHED -- requirements
Module: hvtx_sched

---
 rtl/hvtx_pkg.sv | 20 ++
 rtl/hvtx_dly.sv | 25 ++
 rtl/hvtx_sched.sv | 125 ++++++++++++
 tb/tb_hvtx_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hvtx_pkg.sv
// Shared types and timing constants for the HDMI/DVI transmit period scheduler.
package hvtx_pkg;

  typedef enum logic [1:0] {
    CTRL     = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } mode_t;

  localparam int PRE_LEN = 8;
  localparam int GB_LEN  = 2;
  localparam int LAT     = PRE_LEN + GB_LEN + 1;
  localparam int DLY_W   = 27;

  localparam logic [3:0] CTL_VID_PRE = 4'b0001;
  localparam logic [3:0] PRE_CNT     = 4'(PRE_LEN - 1);
  localparam logic [3:0] GB_CNT      = 4'(GB_LEN - 1);

endpackage

// File: rtl/hvtx_dly.sv
// Fixed-depth shift register with asynchronous active-low clear.
module hvtx_dly #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign o_q = stage[DEPTH-1];

endmodule

// File: rtl/hvtx_sched.sv
// Transmit period scheduler: delays sync/de/video by LAT and sequences encoder modes.
// Define HVTX_HDMI_MODE_EN for HDMI preamble/guard sequencing; default build is DVI-only.
module hvtx_sched
  import hvtx_pkg::*;
(
  input  logic        i_pclk,
  input  logic        i_rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [23:0] i_video,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [23:0] o_video,
  output mode_t       o_mode,
  output logic [3:0]  o_ctl,
  output logic        o_err
);

  logic [DLY_W-1:0] dly_q;
  logic             de_d;

  hvtx_dly #(
    .WIDTH (DLY_W),
    .DEPTH (LAT - 1)
  ) u_dly (
    .i_clk   (i_pclk),
    .i_rst_n (i_rst_n),
    .i_d     ({i_hs, i_vs, i_de, i_video}),
    .o_q     (dly_q)
  );

  // de_d is the value o_de takes on the next cycle, so the FSM can switch in step with it
  assign de_d = dly_q[24];

  // Output register stage
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {o_hs, o_vs, o_de, o_video} <= '0;
    end else begin
      {o_hs, o_vs, o_de, o_video} <= dly_q;
    end
  end

`ifdef HVTX_HDMI_MODE_EN

  logic       de_q;
  logic       pend;
  logic [3:0] cnt;
  logic       rise;
  logic       start_ok;

  assign rise = i_de & ~de_q;
  // A line may be announced only once the previous one is leaving the output and nothing is in flight
  assign start_ok = ~de_d & ~pend & ((o_mode == CTRL) | (o_mode == VIDEO));

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      de_q   <= 1'b0;
      pend   <= 1'b0;
      cnt    <= '0;
      o_mode <= CTRL;
      o_ctl  <= '0;
      o_err  <= 1'b0;
    end else begin
      de_q  <= i_de;
      o_err <= rise & ~start_ok;
      o_ctl <= '0;

      if (rise & ~start_ok) begin
        pend <= 1'b1;
      end else if ((o_mode == CTRL) && de_d) begin
        pend <= 1'b0;
      end

      if (rise & start_ok) begin
        o_mode <= PREAMBLE;
        cnt    <= PRE_CNT;
        o_ctl  <= CTL_VID_PRE;
      end else begin
        case (o_mode)
          CTRL: begin
            // Unannounced line (short blanking) goes straight to video
            if (de_d) o_mode <= VIDEO;
          end
          PREAMBLE: begin
            if (cnt == 4'd0) begin
              o_mode <= GUARD;
              cnt    <= GB_CNT;
            end else begin
              cnt   <= cnt - 4'd1;
              o_ctl <= CTL_VID_PRE;
            end
          end
          GUARD: begin
            if (cnt == 4'd0) o_mode <= VIDEO;
            else             cnt    <= cnt - 4'd1;
          end
          VIDEO: begin
            if (!de_d) o_mode <= CTRL;
          end
          default: o_mode <= CTRL;
        endcase
      end
    end
  end

`else

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mode <= CTRL;
      o_ctl  <= '0;
      o_err  <= 1'b0;
    end else begin
      o_mode <= de_d ? VIDEO : CTRL;
      o_ctl  <= '0;
      o_err  <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_hvtx_sched.sv
// Directed bench for hvtx_sched; expectations follow HVTX_HDMI_MODE_EN when defined.
module tb_hvtx_sched;
  import hvtx_pkg::*;

`ifdef HVTX_HDMI_MODE_EN
  localparam bit HDMI = 1'b1;
`else
  localparam bit HDMI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [23:0] vid = '0;
  logic        o_hs, o_vs, o_de, o_err;
  logic [23:0] o_video;
  mode_t       o_mode;
  logic [3:0]  o_ctl;

  int checks = 0;
  int failures = 0;

  logic [1:0]  md [1024];
  logic [3:0]  ct [1024];
  logic        er [1024];
  logic        od [1024];
  logic [26:0] hist [10240];

  hvtx_sched dut (
    .i_pclk  (clk),
    .i_rst_n (rst_n),
    .i_hs    (hs),
    .i_vs    (vs),
    .i_de    (de),
    .i_video (vid),
    .o_hs    (o_hs),
    .o_vs    (o_vs),
    .o_de    (o_de),
    .o_video (o_video),
    .o_mode  (o_mode),
    .o_ctl   (o_ctl),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    de = 1'b0; hs = 1'b0; vs = 1'b0; vid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drives up to two de pulses and logs outputs per cycle; rstc >= 0 pulses reset at that cycle
  task automatic run(input int s1, input int l1, input int s2, input int l2,
                     input int ncyc, input int rstc);
    for (int c = 0; c < ncyc; c++) begin
      de = ((c >= s1) && (c < s1 + l1)) || ((c >= s2) && (c < s2 + l2));
      md[c] = o_mode; ct[c] = o_ctl; er[c] = o_err; od[c] = o_de;
      if (c == rstc) begin
        rst_n = 1'b0;
        de = 1'b0;
        #2;
        chk("rst_async_outs", {o_hs, o_vs, o_de, o_video, o_mode, o_ctl, o_err}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    de = 1'b0;
  endtask

  task automatic cm(input string scn, input int c, input mode_t eh, input mode_t ed);
    chk($sformatf("%s_mode@%0d", scn, c), md[c], HDMI ? eh : ed);
  endtask

  function automatic int cnt_mode(input mode_t m, input int n);
    int k = 0;
    for (int i = 0; i < n; i++) if (md[i] == m) k++;
    return k;
  endfunction

  function automatic int cnt_err(input int n);
    int k = 0;
    for (int i = 0; i < n; i++) if (er[i]) k++;
    return k;
  endfunction

  function automatic int cnt_ctl(input int lo, input int hi);
    int k = 0;
    for (int i = lo; i <= hi; i++) if (ct[i] == CTL_VID_PRE) k++;
    return k;
  endfunction

  initial begin
    int bad;
    int badm;
    logic [26:0] exp_v;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", o_mode, CTRL);
    chk("rst_outs", {o_hs, o_vs, o_de, o_video, o_ctl, o_err}, 64'd0);
    rst_n = 1'b1;

    // Single long line: rise at 20 held 640 cycles
    run(20, 640, 0, 0, 700, -1);
    cm("A", 20, CTRL, CTRL);
    cm("A", 21, PREAMBLE, CTRL);
    cm("A", 28, PREAMBLE, CTRL);
    cm("A", 29, GUARD, CTRL);
    cm("A", 30, GUARD, CTRL);
    cm("A", 31, VIDEO, VIDEO);
    cm("A", 670, VIDEO, VIDEO);
    cm("A", 671, CTRL, CTRL);
    chk("A_ctl@20", ct[20], 4'd0);
    chk("A_ctl@21", ct[21], HDMI ? CTL_VID_PRE : 4'd0);
    chk("A_ctl@28", ct[28], HDMI ? CTL_VID_PRE : 4'd0);
    chk("A_ctl@29", ct[29], 4'd0);
    chk("A_ctl_in_pre", cnt_ctl(21, 28), HDMI ? 8 : 0);
    chk("A_ctl_total", cnt_ctl(0, 699), HDMI ? 8 : 0);
    chk("A_de@30", od[30], 1'b0);
    chk("A_de@31", od[31], 1'b1);
    chk("A_de@670", od[670], 1'b1);
    chk("A_de@671", od[671], 1'b0);
    chk("A_n_pre", cnt_mode(PREAMBLE, 700), HDMI ? 8 : 0);
    chk("A_n_guard", cnt_mode(GUARD, 700), HDMI ? 2 : 0);
    chk("A_n_video", cnt_mode(VIDEO, 700), 640);
    chk("A_n_err", cnt_err(700), 0);

    // Exactly 10-cycle blanking between two lines
    do_reset();
    run(20, 10, 40, 10, 80, -1);
    cm("B", 40, VIDEO, VIDEO);
    cm("B", 41, PREAMBLE, CTRL);
    cm("B", 48, PREAMBLE, CTRL);
    cm("B", 49, GUARD, CTRL);
    cm("B", 50, GUARD, CTRL);
    cm("B", 51, VIDEO, VIDEO);
    cm("B", 60, VIDEO, VIDEO);
    cm("B", 61, CTRL, CTRL);
    chk("B_n_pre", cnt_mode(PREAMBLE, 80), HDMI ? 16 : 0);
    chk("B_n_guard", cnt_mode(GUARD, 80), HDMI ? 4 : 0);
    chk("B_n_err", cnt_err(80), 0);

    // 5-cycle blanking: violation on the second line
    do_reset();
    run(20, 10, 35, 10, 80, -1);
    chk("C_err@35", er[35], 1'b0);
    chk("C_err@36", er[36], HDMI ? 1'b1 : 1'b0);
    chk("C_n_err", cnt_err(80), HDMI ? 1 : 0);
    cm("C", 40, VIDEO, VIDEO);
    cm("C", 41, CTRL, CTRL);
    cm("C", 45, CTRL, CTRL);
    cm("C", 46, VIDEO, VIDEO);
    cm("C", 55, VIDEO, VIDEO);
    cm("C", 56, CTRL, CTRL);
    chk("C_n_pre", cnt_mode(PREAMBLE, 80), HDMI ? 8 : 0);
    chk("C_n_guard", cnt_mode(GUARD, 80), HDMI ? 2 : 0);
    chk("C_n_video", cnt_mode(VIDEO, 80), 20);

    // Reset pulsed during GUARD, then a fresh short line
    do_reset();
    run(20, 100, 0, 0, 200, 29);
    cm("D", 29, GUARD, CTRL);
    run(20, 5, 0, 0, 50, -1);
    cm("D2", 20, CTRL, CTRL);
    cm("D2", 21, PREAMBLE, CTRL);
    cm("D2", 28, PREAMBLE, CTRL);
    cm("D2", 30, GUARD, CTRL);
    cm("D2", 31, VIDEO, VIDEO);
    cm("D2", 35, VIDEO, VIDEO);
    cm("D2", 36, CTRL, CTRL);
    chk("D2_de@31", od[31], 1'b1);
    chk("D2_n_err", cnt_err(50), 0);

    // Random sync/video: bit-exact 11-cycle delay, de held low
    do_reset();
    bad = 0;
    badm = 0;
    for (int c = 0; c < 10240; c++) begin
      vid = 24'($urandom);
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      de = 1'b0;
      hist[c] = {hs, vs, de, vid};
      exp_v = (c >= LAT) ? hist[c-LAT] : 27'd0;
      if ({o_hs, o_vs, o_de, o_video} !== exp_v) bad++;
      if (o_mode != CTRL || o_ctl != 4'd0 || o_err != 1'b0) badm++;
      @(posedge clk); #1;
    end
    chk("E_dly_bitexact_bad", bad, 0);
    chk("E_ctrl_only_bad", badm, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
